fir_tap_sequencer: RTL
======================

Name: fir_tap_sequencer

Overview:
Controller for a single dual-port sample RAM used as a circular FIR delay line. For each accepted input sample it writes the sample at the write pointer. It then issues TAPS consecutive reads, newest to oldest, with a matching coefficient index. Outputs are tap_valid/first/last strobes aligned with the RAM's 1-cycle registered read data, so a downstream MAC needs no extra alignment. It also sequences a zero-fill flush of the delay line.

Parameters:
BITS, 16, sample width (matches RAM data width)
SIZE, 256, RAM depth in words; must be a power of 2
TAPS, 32, taps read per sample; 1 <= TAPS <= SIZE
AWIDTH, $clog2(SIZE), RAM address width
CWIDTH, $clog2(TAPS) (min 1), coefficient index width

Ports:
ck  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  sample strobe
in_data  in  BITS  sample
in_ready  out  1  high when a sample can be accepted (= !busy)
flush  in  1  request zero-fill of the delay line
clr_overrun  in  1  clear sticky overrun flag
busy  out  1  sequencer active (state != IDLE)
overrun  out  1  sticky: a sample or flush was dropped
ram_we  out  1  RAM write enable
ram_waddr  out  AWIDTH  RAM write address
ram_wdata  out  BITS  RAM write data
ram_re  out  1  RAM read enable
ram_raddr  out  AWIDTH  RAM read address
coef_addr  out  CWIDTH  coefficient index; presented with ram_raddr (coef ROM has 1-cycle latency)
tap_valid  out  1  RAM rdata is a valid tap this cycle
tap_first  out  1  with tap_valid: tap 0 (newest sample)
tap_last  out  1  with tap_valid: tap TAPS-1; marks end of sample

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE and wptr=0.
  - All outputs are 0, including overrun. in_ready follows !busy, so it is 1 once out of reset.
  - RAM contents are not touched.
- All RAM-side outputs are combinational from the registered state and pointers. tap_* are registered copies of ram_re/first/last, delayed 1 cycle.
- FSM states: IDLE, RUN, FLUSH.
- IDLE:
  - flush=1: go to FLUSH with fidx=0. flush has priority over a same-cycle in_valid. That sample is dropped and overrun is set.
  - else in_valid=1: ram_we=1, ram_waddr=wptr, ram_wdata=in_data. Latch base=wptr, set wptr=wptr+1 (mod SIZE), set idx=0, go to RUN.
- RUN, each cycle:
  - ram_re=1, ram_raddr=(base-idx) mod SIZE (AWIDTH truncation), coef_addr=idx.
  - Internal first flag = (idx==0); internal last flag = (idx==TAPS-1).
  - idx increments each cycle. After the idx==TAPS-1 cycle, return to IDLE.
- Read-after-write: the first RUN read hits the address written in the previous cycle. The RAM registers the write on that edge, so the read returns the new sample. No bypass is required.
- Timing (accept at cycle 0):
  - ram_re is high in cycles 1..TAPS.
  - tap_valid is high in cycles 2..TAPS+1; tap_first in cycle 2, tap_last in cycle TAPS+1.
  - The next accept is possible at cycle TAPS+1, so throughput is one sample per TAPS+1 cycles.
- TAPS=1: tap_first and tap_last are asserted together.
- FLUSH:
  - Each cycle: ram_we=1, ram_waddr=fidx, ram_wdata=0.
  - After fidx=SIZE-1, set wptr=0 and go to IDLE. Duration is SIZE cycles; no reads are issued.
- in_valid or flush while busy=1: the request is dropped and overrun is set. The FSM is unaffected.
- overrun:
  - clr_overrun clears it.
  - Set has priority over a same-cycle clear.
- Wrap-around: wptr and read addresses wrap modulo SIZE. Reads may return stale or flushed data for taps older than the samples written since flush; this is expected.
- Reset mid-RUN or mid-FLUSH: the operation aborts immediately. No tap_last is produced, and a partial flush is not completed.

Decomposition:
- Shared DSP package holds:
  - FSM state encoding (IDLE/RUN/FLUSH).
  - A localparam helper for the CWIDTH minimum of 1.
- No sub-module inside the controller.
- The RAM is instantiated beside it by the parent, connected port-for-port (same ck).
- The test bench instantiates the RAM, BITS/SIZE matched.

Test Plan:
All scenarios use SIZE=8, TAPS=4.
- Samples 1,2,3,4,5, spaced 6 cycles apart:
  - After sample 5, taps in order are 5,4,3,2 with coef_addr 0,1,2,3.
  - tap_first is on the 5, tap_last on the 2.
  - Taps are exactly 2..5 cycles after accept.
- 9 samples (wraps wptr): after sample 9, ram_raddr sequence is 0,7,6,5 and taps are 9,8,7,6.
- Flush after 3 samples, then sample 10:
  - Flush produces 8 zero writes with busy high for 8 cycles.
  - Sample 10 is written at addr 0; taps are 10,0,0,0.
- in_valid on cycle 2 of a RUN:
  - overrun=1 and in_ready=0 at that point; the sample is not written.
  - The current taps complete unchanged.
  - clr_overrun clears overrun to 0.
- flush and in_valid together in IDLE: FLUSH is entered, overrun=1, and no sample write occurs.
- rst_n low during tap 2 of RUN:
  - All outputs go to 0 immediately and no tap_last is seen.
  - After release, the next sample is written at addr 0.

Source files
------------

// File: rtl/fir_tap_sequencer_pkg.sv
// Shared definitions for the FIR tap sequencer.
//   seq_state_e  : sequencer FSM encoding (idle / tap read run / zero-fill flush)
//   cwidth_min1  : coefficient index width, never narrower than one bit
package fir_tap_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2
  } seq_state_e;

  // $clog2(1) is 0, which would give a zero-width coefficient index for TAPS=1.
  function automatic int unsigned cwidth_min1(input int unsigned taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

endpackage

// File: rtl/fir_tap_sequencer.sv
// Controller for a dual-port sample RAM used as a circular FIR delay line.
// Each accepted sample is written at the write pointer, then TAPS reads are issued from the
// newest to the oldest sample together with the matching coefficient index. tap_* strobes are
// delayed one cycle so they line up with the RAM's registered read data. A flush request
// zero-fills the whole RAM and restarts the write pointer at 0.
//
// Ports:
//   ck, rst_n                    clock, asynchronous active-low reset
//   in_valid, in_data, in_ready  sample input (accepted only while idle)
//   flush                        request a zero-fill of the delay line
//   clr_overrun                  clear the sticky overrun flag
//   busy, overrun                status: sequencer active / a request was dropped
//   ram_we, ram_waddr, ram_wdata RAM write port
//   ram_re, ram_raddr            RAM read port
//   coef_addr                    coefficient index, presented with ram_raddr
//   tap_valid, tap_first, tap_last  strobes aligned with RAM read data
module fir_tap_sequencer
  import fir_tap_sequencer_pkg::*;
#(
  parameter int unsigned BITS   = 16,
  parameter int unsigned SIZE   = 256,
  parameter int unsigned TAPS   = 32,
  parameter int unsigned AWIDTH = $clog2(SIZE),
  parameter int unsigned CWIDTH = cwidth_min1(TAPS)
) (
  input  logic              ck,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [BITS-1:0]   in_data,
  output logic              in_ready,
  input  logic              flush,
  input  logic              clr_overrun,
  output logic              busy,
  output logic              overrun,
  output logic              ram_we,
  output logic [AWIDTH-1:0] ram_waddr,
  output logic [BITS-1:0]   ram_wdata,
  output logic              ram_re,
  output logic [AWIDTH-1:0] ram_raddr,
  output logic [CWIDTH-1:0] coef_addr,
  output logic              tap_valid,
  output logic              tap_first,
  output logic              tap_last
);

  localparam logic [CWIDTH-1:0] LastIdx  = CWIDTH'(TAPS - 1);
  localparam logic [AWIDTH-1:0] LastAddr = AWIDTH'(SIZE - 1);

  seq_state_e        state_q, state_d;
  logic [AWIDTH-1:0] wptr_q, wptr_d;
  logic [AWIDTH-1:0] base_q, base_d;
  logic [AWIDTH-1:0] fidx_q, fidx_d;
  logic [CWIDTH-1:0] idx_q, idx_d;
  logic              overrun_q, overrun_d;
  logic              tap_valid_q, tap_valid_d;
  logic              tap_first_q, tap_first_d;
  logic              tap_last_q, tap_last_d;

  logic rd_first;
  logic rd_last;
  logic drop;

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    base_d    = base_q;
    fidx_d    = fidx_q;
    idx_d     = idx_q;
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    ram_re    = 1'b0;
    ram_raddr = '0;
    coef_addr = '0;
    rd_first  = 1'b0;
    rd_last   = 1'b0;
    drop      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (flush) begin
          // Flush wins; a coincident sample is lost.
          state_d = StFlush;
          fidx_d  = '0;
          drop    = in_valid;
        end else if (in_valid) begin
          ram_we    = 1'b1;
          ram_waddr = wptr_q;
          ram_wdata = in_data;
          base_d    = wptr_q;
          wptr_d    = wptr_q + AWIDTH'(1);
          idx_d     = '0;
          state_d   = StRun;
        end
      end
      StRun: begin
        ram_re    = 1'b1;
        // Newest to oldest; wraps naturally through AWIDTH truncation.
        ram_raddr = base_q - AWIDTH'(idx_q);
        coef_addr = idx_q;
        rd_first  = (idx_q == '0);
        rd_last   = (idx_q == LastIdx);
        idx_d     = idx_q + CWIDTH'(1);
        drop      = in_valid | flush;
        if (rd_last) begin
          state_d = StIdle;
        end
      end
      StFlush: begin
        ram_we    = 1'b1;
        ram_waddr = fidx_q;
        fidx_d    = fidx_q + AWIDTH'(1);
        drop      = in_valid | flush;
        if (fidx_q == LastAddr) begin
          wptr_d  = '0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A drop in the same cycle as a clear must still leave the flag set.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    tap_valid_d = ram_re;
    tap_first_d = rd_first;
    tap_last_d  = rd_last;
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wptr_q      <= '0;
      base_q      <= '0;
      fidx_q      <= '0;
      idx_q       <= '0;
      overrun_q   <= 1'b0;
      tap_valid_q <= 1'b0;
      tap_first_q <= 1'b0;
      tap_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      base_q      <= base_d;
      fidx_q      <= fidx_d;
      idx_q       <= idx_d;
      overrun_q   <= overrun_d;
      tap_valid_q <= tap_valid_d;
      tap_first_q <= tap_first_d;
      tap_last_q  <= tap_last_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign in_ready  = ~busy;
  assign overrun   = overrun_q;
  assign tap_valid = tap_valid_q;
  assign tap_first = tap_first_q;
  assign tap_last  = tap_last_q;

endmodule
